// File: rtl/xtor_pkg.sv
// Shared transactor definitions: request word type and default buffer sizing.
package xtor_pkg;

    localparam int XTOR_DATA_W         = 32;
    localparam int XTOR_REQ_FIFO_DEPTH = 4;

    typedef logic [XTOR_DATA_W-1:0] xtor_data_t;

endpackage : xtor_pkg

// File: rtl/xtor_req_fifo_mem.sv
// Plain DEPTH x DATA_W register array with one write port and a combinational read port.
module xtor_req_fifo_mem
    import xtor_pkg::*;
#(
    parameter int DATA_W = XTOR_DATA_W,
    parameter int DEPTH  = XTOR_REQ_FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; the count in the top masks stale entries.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : xtor_req_fifo_mem

// File: rtl/xtor_req_fifo.sv
// Request-side FWFT buffer in front of the transactor core.
// Optional statistics counters are enabled with `define XTOR_REQ_FIFO_STATS_EN.
module xtor_req_fifo
    import xtor_pkg::*;
#(
    parameter int DATA_W = XTOR_DATA_W,
    parameter int DEPTH  = XTOR_REQ_FIFO_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level
`ifdef XTOR_REQ_FIFO_STATS_EN
    ,
    output logic [31:0]            push_count,
    output logic [31:0]            pop_count,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    logic [DATA_W-1:0] rd_data;

    // in_ready is gated by reset so the driver sees a refusal for the whole reset window.
    assign in_ready  = reset && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? rd_data : '0;
    assign level     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    xtor_req_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

`ifdef XTOR_REQ_FIFO_STATS_EN
    logic [31:0] push_count_q, pop_count_q, stall_cycles_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            push_count_q   <= '0;
            pop_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (push) begin
                push_count_q <= push_count_q + 32'd1;
            end
            if (pop) begin
                pop_count_q <= pop_count_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign push_count   = push_count_q;
    assign pop_count    = pop_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule : xtor_req_fifo

// File: doc/xtor_req_fifo.md
Name: xtor_req_fifo

Overview:
- Request-side buffer sitting directly upstream of the transactor core.
- Accepts data words from the bench-side driver and holds them in a small FIFO.
- Presents them to the core's valid/data_i inputs, advancing only on valid && ready.
- Decouples driver timing from the core's registered ready, which is low for at least one cycle after reset.

Parameters:
DATA_W, 32, width of each request word (matches core data_i)
DEPTH, 4, number of FIFO entries; power of two, >= 2

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous reset, active-low (asserted at 0)
in_valid  input  1  driver offers in_data this cycle
in_ready  output  1  FIFO can accept a word this cycle
in_data  input  DATA_W  request word from driver
out_valid  output  1  to core valid; head entry present
out_ready  input  1  from core ready
out_data  output  DATA_W  to core data_i; head entry
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x DATA_W array, write pointer wr_ptr, read pointer rd_ptr (each $clog2(DEPTH) bits), occupancy count. Array is not reset.
- Reset (reset==0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: out_valid=0, out_data=0, level=0, in_ready=0 (forced low while reset asserted).
- After reset release: in_ready=1 from the first clock edge's evaluation onward.
- Push:
  - in_valid && in_ready at a rising edge writes in_data to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0 with no gap.
- Pop:
  - out_valid && out_ready at a rising edge retires the head.
  - rd_ptr increments modulo DEPTH with the same wrap.
- in_ready = (count != DEPTH) while out of reset. Combinational from registered count only; no dependency on out_ready (no pass-through when full).
- out_valid = (count != 0). out_data = mem[rd_ptr] when count != 0, else 0 (first-word-fall-through).
- Latency: a word pushed into an empty FIFO appears on out_valid/out_data at the next edge (1 cycle). No same-cycle bypass.
- Simultaneous push and pop when 0<count<DEPTH: both happen, count unchanged.
- When full: push refused (in_ready=0), so a pop leaves count=DEPTH-1.
- When empty: pop impossible (out_valid=0), so a push leaves count=1.
- Stability: out_data and out_valid hold until popped. out_ready may toggle freely, and a stalled head never changes.
- Driver protocol: held in_valid with changing in_data is legal; each accepted edge captures the current in_data.
- level = count, registered.
- Reset mid-operation discards all contents immediately. out_valid drops asynchronously, and no partially written entry is visible afterward.
- Words exit in strict push order with no loss or duplication.

Optional Feature:
- Macro: XTOR_REQ_FIFO_STATS_EN.
- When defined, adds ports:
  - push_count output 32: total accepted pushes.
  - pop_count output 32: total pops.
  - stall_cycles output 32: cycles with out_valid=1 && out_ready=0.
- All three counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared package xtor_pkg holds:
  - typedef xtor_data_t (logic [31:0]), used by core and FIFO.
  - localparam XTOR_DATA_W = 32.
  - localparam XTOR_REQ_FIFO_DEPTH = 4.
- One natural sub-module: xtor_req_fifo_mem, the plain DEPTH x DATA_W register array (write port plus combinational read). Pointer/count control stays in the top.

Test Plan:
- Reset release, then in_valid=1 with data 0x10 at cycle 1 -> in_ready=1; out_valid=1, out_data=0x10, level=1 at next edge.
- out_ready=0, push 0xA,0xB,0xC,0xD -> level=4, in_ready=0; 5th word 0xE held and not accepted; out_data stays 0xA.
- From full, assert out_ready=1 for 4 cycles with no pushes -> out_data sequence 0xA,0xB,0xC,0xD, then out_valid=0, out_data=0, level=0.
- Continuous push and pop of incrementing words 1..20 with out_ready=1 -> all 20 exit in order, level constant at 1 after warm-up, pointers wrap five times.
- Mid-stream reset: level=3, pull reset low for 1 cycle -> out_valid=0, in_ready=0 immediately. After release, level=0, and first new push 0x55 is the first word out.
- With XTOR_REQ_FIFO_STATS_EN: 6 pushes, 6 pops with out_ready low for 3 cycles while non-empty -> push_count=6, pop_count=6, stall_cycles=3.
